memory_port_arbiter: RTL and testbench
======================================

# memory_port_arbiter

Shares the single main-memory port between the instruction cache and the data cache. It accepts block read/write requests from both caches, grants the port to exactly one of them at a time and holds that grant until the memory completes. It routes memory read data back to the granted cache and drives each cache's busywait. It sits between the two caches and main memory, so only one cache needs to own the memory interface at a time.

## Interface
- ADDR_WIDTH, 28: block address width (byte address bits [31:4]).
- DATA_WIDTH, 128: cache block width in bits.
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clock.
- i_read  in  1  icache block-read request; held until i_busywait low.
- i_address  in  ADDR_WIDTH  icache block address.
- i_readdata  out  DATA_WIDTH  block returned to icache.
- i_busywait  out  1  icache stall.
- d_read, d_write  in  1 each  dcache block read / write-back request; held until d_busywait low.
- d_address  in  ADDR_WIDTH  dcache block address.
- d_writedata  in  DATA_WIDTH  dcache write-back block.
- d_readdata  out  DATA_WIDTH  block returned to dcache.
- d_busywait  out  1  dcache stall.
- mem_read, mem_write  out  1 each  memory commands.
- mem_address  out  ADDR_WIDTH  memory block address.
- mem_writedata  out  DATA_WIDTH  memory write block.
- mem_readdata  in  DATA_WIDTH  memory read block.
- mem_busywait  in  1  memory busy; raised no later than 1 cycle after command asserted.

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D, RELEASE. State is registered.
- IDLE:
  - No request: stay in IDLE.
  - Only i_read: go to GRANT_I.
  - Any d request: go to GRANT_D.
  - Both caches requesting: arbitration rule applies (see Configuration).
- GRANT_x:
  - mem_* driven combinationally from cache x's inputs.
  - Other cache's command is not forwarded.
- Issue cycle: the first cycle of GRANT_x. mem_busywait is ignored in this cycle.
- Completion:
  - Condition: in GRANT_x, not the issue cycle, and mem_busywait==0.
  - x_busywait drops for that cycle only.
  - x_readdata = mem_readdata for reads.
  - Next state is RELEASE.
- RELEASE:
  - All mem_* commands are 0 for one cycle so memory sees the deassertion.
  - Next state: IDLE, or directly GRANT_* by the same arbitration rule if requests are pending.
- d_read and d_write both high: d_write is served. The d_read is then re-arbitrated as a new request.
- x_busywait = x request asserted AND NOT completion-for-x this cycle. This holds in every state, including RELEASE.
- A requester dropping its request mid-grant is illegal. The grant is held to completion regardless, and the result is discarded.
- x_readdata is 0 whenever x is not completing.
- mem_address and mem_writedata are 0 whenever no grant is active.

## Timing
- Reset: state=IDLE; RR pointer=I. Registered outputs reset to 0.
- While reset is high: mem_read, mem_write, mem_address, mem_writedata, i_readdata, d_readdata = 0. i_busywait/d_busywait follow their request inputs.
- Reset mid-grant: the transaction is abandoned and memory sees the command drop on the next cycle.
- Latency, request to command:
  - Request sampled high at edge N in IDLE.
  - mem_read/mem_write asserted during cycle N+1 (GRANT).
- Minimum transaction, memory finishing in 1 busy cycle: GRANT ×2 cycles, then RELEASE ×1. Back-to-back grant period is therefore ≥3 cycles.
- No combinational path from mem_busywait to mem_read/mem_write.

## Configuration
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - Simultaneous requests go to the cache not served last (1-bit pointer, updated on each completion; reset value I).
  - A cache can wait at most one foreign transaction.
- Undefined:
  - Fixed priority: dcache always wins simultaneous arbitration.
  - The pointer register is not built.

## Test plan
- Single icache read, address 0x0000010, memory busy 4 cycles:
  - mem_read high cycles 1–5, address 0x0000010.
  - i_busywait low only in cycle 5, with i_readdata = memory block.
  - RELEASE in cycle 6 with mem_read=0.
- Simultaneous i_read and d_read at cycle 0:
  - Without the macro: d served first, i served next, i_busywait high throughout d's grant.
  - With the macro: same order first time; repeat both requests and i is served first.
- d_write and d_read both high: mem_write with d_writedata is issued first, then a separate mem_read. d_busywait drops once per transaction.
- Reset asserted during cycle 2 of a d_read grant: next cycle mem_read=0 and state IDLE. A new i_read afterwards is granted normally.
- Continuous icache requests with one dcache request arriving mid-grant (macro defined): the dcache grant begins right after the current RELEASE. The icache is not granted twice in a row.

Source files
------------

// File: rtl/memory_port_arbiter.sv
// ---------------------------------------------------------------------------
// memory_port_arbiter
//
// Shares the single main-memory port between the instruction cache and the
// data cache. One cache at a time owns the port; the grant is held until the
// memory completes, followed by one RELEASE cycle with all commands low so
// the memory sees the deassertion before the next transaction.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : simultaneous requests go to the cache not served last
//   undefined : fixed priority, the dcache wins simultaneous requests
//
// Ports
//   clock, reset           system clock; synchronous active-high reset
//   i_read, i_address      icache block-read request and address
//   i_readdata, i_busywait block returned to icache, icache stall
//   d_read, d_write        dcache block read / write-back request
//   d_address, d_writedata dcache block address and write-back block
//   d_readdata, d_busywait block returned to dcache, dcache stall
//   mem_read, mem_write    memory commands
//   mem_address            memory block address
//   mem_writedata          memory write block
//   mem_readdata           memory read block
//   mem_busywait           memory busy
// ---------------------------------------------------------------------------
module memory_port_arbiter #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [DATA_WIDTH-1:0] i_readdata,
  output logic                  i_busywait,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [DATA_WIDTH-1:0] d_writedata,
  output logic [DATA_WIDTH-1:0] d_readdata,
  output logic                  d_busywait,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  input  logic                  mem_busywait
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t state;
  state_t next_state;
  state_t arb_choice;

  logic issue;        // first cycle of a grant: mem_busywait is not yet valid
  logic d_op_write;   // dcache operation latched at grant start (write wins)
  logic d_req;
  logic d_wins_tie;
  logic start_grant;
  logic grant_i;
  logic grant_d;
  logic complete;
  logic i_complete;
  logic d_complete;

  assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers which cache completed last; 0 = icache (reset value).
  logic last_d;
  assign d_wins_tie = ~last_d;
`else
  assign d_wins_tie = 1'b1;
`endif

  // Reset gates the grant immediately, so the memory command and any
  // completion vanish in the very cycle reset is sampled high.
  assign grant_i    = ~reset & (state == GRANT_I);
  assign grant_d    = ~reset & (state == GRANT_D);
  assign complete   = (grant_i | grant_d) & ~issue & ~mem_busywait;
  assign i_complete = grant_i & complete;
  assign d_complete = grant_d & complete;

  assign start_grant = ((state == IDLE) || (state == RELEASE)) && (arb_choice != IDLE);

  // State register
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state      <= IDLE;
      issue      <= 1'b0;
      d_op_write <= 1'b0;
    end else begin
      state <= next_state;
      issue <= start_grant;
      if (start_grant && (arb_choice == GRANT_D)) begin
        d_op_write <= d_write;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      last_d <= 1'b0;
    end else if (i_complete) begin
      last_d <= 1'b0;
    end else if (d_complete) begin
      last_d <= 1'b1;
    end
  end
`endif

  // Next-state logic
  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    arb_choice = IDLE;
    next_state = state;

    if (d_req && (!i_read || d_wins_tie)) begin
      arb_choice = GRANT_D;
    end else if (i_read) begin
      arb_choice = GRANT_I;
    end

    case (state)
      IDLE, RELEASE: next_state = arb_choice;
      GRANT_I, GRANT_D: begin
        if (complete) begin
          next_state = RELEASE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;

    if (grant_i) begin
      mem_read    = 1'b1;
      mem_address = i_address;
    end else if (grant_d) begin
      mem_read      = ~d_op_write;
      mem_write     = d_op_write;
      mem_address   = d_address;
      mem_writedata = d_writedata;
    end

    i_busywait = i_read & ~i_complete;
    d_busywait = d_req & ~d_complete;
    i_readdata = i_complete ? mem_readdata : '0;
    d_readdata = (d_complete && !d_op_write) ? mem_readdata : '0;
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_memory_port_arbiter
//
// Self-checking bench for memory_port_arbiter. A transaction-level model
// (owner / cycles-in-grant / last-served) predicts every output each cycle;
// directed scenarios pin the model with hand-computed literal expectations,
// then a randomized phase drives both caches, random memory latency and
// occasional resets. Honours ARB_ROUND_ROBIN_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_memory_port_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [DW-1:0] LIT1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [DW-1:0] LIT2 = 128'hCAFE_F00D_1357_9BDF_2468_ACE0_DEAD_BEEF;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [DW-1:0] i_readdata;
  logic          i_busywait;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [DW-1:0] d_writedata = '0;
  logic [DW-1:0] d_readdata;
  logic          d_busywait;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;
  logic          mem_busywait;

  always #5 clock = ~clock;

  memory_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock        (clock),
    .reset        (reset),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_readdata   (i_readdata),
    .i_busywait   (i_busywait),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_writedata  (d_writedata),
    .d_readdata   (d_readdata),
    .d_busywait   (d_busywait),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  // ---------------- memory: busy for blen cycles starting at the issue cycle
  int unsigned   run = 0;
  int unsigned   blen = 1;
  int unsigned   force_len = 0;
  logic [DW-1:0] rd_block = '0;
  logic          mem_cmd;

  assign mem_cmd      = mem_read | mem_write;
  assign mem_busywait = mem_cmd && (run < blen);
  assign mem_readdata = rd_block;

  always @(posedge clock) begin
    if (mem_cmd) begin
      run <= run + 1;
    end else begin
      run  <= 0;
      blen <= (force_len != 0) ? force_len : $urandom_range(4, 1);
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- bookkeeping
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [DW-1:0] actual,
                       input logic [DW-1:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
  endtask

  // ---------------- monitor: completion / issue logs for directed checks
  logic          i_done_seen = 1'b0;
  logic          d_done_seen = 1'b0;
  logic [1:0]    prev_cmd = 2'b00;
  int            comp_q[$];
  int            comp_cyc[$];
  logic [1:0]    iss_type[$];
  logic [AW-1:0] iss_addr[$];
  logic [DW-1:0] iss_wd[$];
  int            iss_cyc[$];

  initial begin : monitor
    forever begin
      @(negedge clock);
      i_done_seen = i_read && !i_busywait;
      d_done_seen = (d_read || d_write) && !d_busywait;
      if (i_done_seen) begin comp_q.push_back(1); comp_cyc.push_back(cyc); end
      if (d_done_seen) begin comp_q.push_back(2); comp_cyc.push_back(cyc); end
      if ({mem_write, mem_read} != 2'b00 && prev_cmd == 2'b00) begin
        iss_type.push_back({mem_write, mem_read});
        iss_addr.push_back(mem_address);
        iss_wd.push_back(mem_writedata);
        iss_cyc.push_back(cyc);
      end
      prev_cmd = {mem_write, mem_read};
    end
  end

  task automatic clear_logs();
    comp_q.delete(); comp_cyc.delete();
    iss_type.delete(); iss_addr.delete(); iss_wd.delete(); iss_cyc.delete();
  endtask

  // ---------------- reference model: who owns the port and for how long
  int            owner = 0;   // 0 none, 1 icache, 2 dcache
  int            age   = 0;   // cycles already spent in the current grant
  int            last  = 1;   // cache that completed last
  logic          wop   = 1'b0;
  logic          done, dreq;
  logic          e_mr, e_mw, e_ib, e_db;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd, e_ird, e_drd;
  int            win;

  initial begin : compare
    forever begin
      @(negedge clock);
      dreq = d_read | d_write;
      done = 1'b0;
      if (reset) begin
        e_mr = 1'b0; e_mw = 1'b0; e_addr = '0; e_wd = '0;
        e_ird = '0; e_drd = '0; e_ib = i_read; e_db = dreq;
      end else begin
        done   = (owner != 0) && (age > 0) && !mem_busywait;
        e_mr   = (owner == 1) || (owner == 2 && !wop);
        e_mw   = (owner == 2) && wop;
        e_addr = (owner == 1) ? i_address : (owner == 2) ? d_address : '0;
        e_wd   = (owner == 2) ? d_writedata : '0;
        e_ird  = (done && owner == 1) ? mem_readdata : '0;
        e_drd  = (done && owner == 2 && !wop) ? mem_readdata : '0;
        e_ib   = i_read && !(done && owner == 1);
        e_db   = dreq && !(done && owner == 2);
      end
      check("mem_read",      DW'(mem_read),      DW'(e_mr));
      check("mem_write",     DW'(mem_write),     DW'(e_mw));
      check("mem_address",   DW'(mem_address),   DW'(e_addr));
      check("mem_writedata", mem_writedata,      e_wd);
      check("i_readdata",    i_readdata,         e_ird);
      check("d_readdata",    d_readdata,         e_drd);
      check("i_busywait",    DW'(i_busywait),    DW'(e_ib));
      check("d_busywait",    DW'(d_busywait),    DW'(e_db));
      // advance to the next cycle
      if (reset) begin
        owner = 0; last = 1;
      end else if (owner != 0) begin
        if (done) begin last = owner; owner = 0; end
        else age++;
      end else begin
        win = 0;
        if (i_read && dreq) win = RR ? ((last == 1) ? 2 : 1) : 2;
        else if (dreq)      win = 2;
        else if (i_read)    win = 1;
        owner = win; age = 0; wop = d_write;
      end
    end
  end

  // ---------------- cache agents
  logic i_cont    = 1'b0;  // icache re-requests immediately after completion
  int   d_cont    = 0;     // extra dcache reads issued back to back
  logic rand_mode = 1'b0;

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic agent_step();
    if (i_done_seen) begin
      if (i_cont) i_address = i_address + 28'd1;
      else        i_read = 1'b0;
    end
    if (d_done_seen) begin
      if (d_write)         d_write = 1'b0;
      else if (d_cont > 0) begin d_cont--; d_address = d_address + 28'd1; end
      else                 d_read = 1'b0;
    end
    if (rand_mode) begin
      reset = ($urandom_range(199, 0) == 0);
      if (!i_read && $urandom_range(2, 0) == 0) begin
        i_read = 1'b1; i_address = AW'($urandom);
      end
      if (!d_read && !d_write && $urandom_range(2, 0) == 0) begin
        case ($urandom_range(2, 0))
          0:       d_read = 1'b1;
          1:       d_write = 1'b1;
          default: begin d_read = 1'b1; d_write = 1'b1; end
        endcase
        d_address   = AW'($urandom);
        d_writedata = {$urandom, $urandom, $urandom, $urandom};
      end
      rd_block = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_cont = 1'b0; d_cont = 0; rand_mode = 1'b0;
    repeat (2) next_cycle();
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic wait_comp(input int target, input int budget, input string name);
    int n = 0;
    while (comp_q.size() < target && n < budget) begin
      next_cycle(); agent_step(); n++;
    end
    check(name, DW'(comp_q.size()), DW'(target));
  endtask

  // ---------------- directed scenarios, then random traffic
  int            hi, dc, low_cnt, r6, n;
  logic [AW-1:0] a1;
  logic [DW-1:0] got;

  initial begin
    // reset state: commands low, busywait follows the request
    next_cycle();
    d_read = 1'b1;
    @(negedge clock);
    check("rst_mem_read",    DW'(mem_read),    DW'(0));
    check("rst_mem_address", DW'(mem_address), DW'(0));
    check("rst_d_busywait",  DW'(d_busywait),  DW'(1));
    check("rst_i_busywait",  DW'(i_busywait),  DW'(0));

    // 1) single icache read, memory busy 4 cycles
    do_reset();
    force_len = 4; rd_block = LIT1;
    i_read = 1'b1; i_address = 28'h0000010;
    hi = 0; dc = -1; low_cnt = 0; r6 = -1; a1 = '0; got = '0;
    for (int k = 1; k <= 7; k++) begin
      next_cycle(); agent_step();
      @(negedge clock);
      if (mem_read) hi++;
      if (k == 1) a1 = mem_address;
      if (i_read && !i_busywait) begin low_cnt++; dc = k; got = i_readdata; end
      if (k == 6) r6 = int'(mem_read | mem_write);
    end
    check("t1_read_cycles",  DW'(hi),      DW'(5));
    check("t1_address",      DW'(a1),      DW'(28'h0000010));
    check("t1_done_cycle",   DW'(dc),      DW'(5));
    check("t1_busy_low_cnt", DW'(low_cnt), DW'(1));
    check("t1_readdata",     got,          LIT1);
    check("t1_release_cmd",  DW'(r6),      DW'(0));

    // 2) simultaneous requests; the dcache then re-requests at once
    do_reset();
    force_len = 1;
    i_read = 1'b1; i_address = 28'h0000100;
    d_read = 1'b1; d_address = 28'h0000200; d_cont = 1;
    wait_comp(3, 40, "t2_completions");
    if (comp_q.size() >= 3) begin
      check("t2_first",  DW'(comp_q[0]), DW'(2));
      check("t2_second", DW'(comp_q[1]), DW'(RR ? 1 : 2));
      check("t2_third",  DW'(comp_q[2]), DW'(RR ? 2 : 1));
    end

    // 3) write-back and read together: write first, then a separate read
    do_reset();
    force_len = 2;
    d_write = 1'b1; d_read = 1'b1; d_address = 28'h0000333; d_writedata = LIT2;
    wait_comp(2, 40, "t3_completions");
    repeat (3) begin next_cycle(); agent_step(); end
    check("t3_total_done",  DW'(comp_q.size()),   DW'(2));
    check("t3_total_issue", DW'(iss_type.size()), DW'(2));
    if (iss_type.size() >= 2) begin
      check("t3_first_is_write", DW'(iss_type[0]), DW'(2'b10));
      check("t3_write_data",     iss_wd[0],        LIT2);
      check("t3_second_is_read", DW'(iss_type[1]), DW'(2'b01));
    end

    // 4) reset in cycle 2 of a dcache read grant, then a fresh icache read
    do_reset();
    force_len = 4;
    d_read = 1'b1; d_address = 28'h0000444;
    next_cycle(); agent_step();
    @(negedge clock);
    check("t4_issue", DW'(mem_read), DW'(1));
    next_cycle(); agent_step();
    reset = 1'b1;
    @(negedge clock);
    check("t4_rst_cmd",  DW'(mem_read),   DW'(0));
    check("t4_rst_busy", DW'(d_busywait), DW'(1));
    next_cycle();
    reset = 1'b0; d_read = 1'b0; i_read = 1'b1; i_address = 28'h0000555;
    @(negedge clock);
    check("t4_idle_cmd", DW'(mem_read | mem_write), DW'(0));
    next_cycle(); agent_step();
    @(negedge clock);
    check("t4_new_grant", DW'(mem_read),    DW'(1));
    check("t4_new_addr",  DW'(mem_address), DW'(28'h0000555));
    clear_logs();
    wait_comp(1, 20, "t4_completions");
    if (comp_q.size() >= 1) check("t4_who", DW'(comp_q[0]), DW'(1));

    // 5) continuous icache traffic, a dcache read arrives mid-grant
    do_reset();
    force_len = 3; i_cont = 1'b1;
    i_read = 1'b1; i_address = 28'h0000100;
    repeat (2) begin next_cycle(); agent_step(); end
    d_read = 1'b1; d_address = 28'h00002AA;
    n = 0;
    while (iss_addr.size() < 3 && n < 60) begin next_cycle(); agent_step(); n++; end
    check("t5_issues", DW'(iss_addr.size()), DW'(3));
    if (iss_addr.size() >= 3 && comp_cyc.size() >= 1) begin
      check("t5_first",  DW'(iss_addr[0]), DW'(28'h0000100));
      check("t5_second", DW'(iss_addr[1]), DW'(28'h00002AA));
      check("t5_third",  DW'(iss_addr[2]), DW'(28'h0000101));
      check("t5_d_right_after_release", DW'(iss_cyc[1] - comp_cyc[0]), DW'(2));
    end

    // random traffic with random latency and occasional resets
    do_reset();
    force_len = 0; rand_mode = 1'b1;
    repeat (3000) begin next_cycle(); agent_step(); end
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
